// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: transfer
// lengths, controller state and owner encodings, and the default address width.
package mem_ctrl_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;

  // mem_len encodings; 2'b10 is also treated as a word.
  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2
  } mc_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Number of bytes moved for a given mem_len encoding.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side handshake bundle of the memory controller: fetch port,
// data port and the per-port stall requests.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [31:0]       if_data;
  logic              if_done;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;

  logic              if_stall;
  logic              mem_stall;

  // Pipeline side.
  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  if_data, if_done, mem_rdata, mem_done, if_stall, mem_stall
  );

  // Controller side.
  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output if_data, if_done, mem_rdata, mem_done, if_stall, mem_stall
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetches and data accesses onto an
// 8-bit synchronous RAM port, one byte per cycle, little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  mem_ctrl_if.slave         bus,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  mc_state_e         state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        num_q, num_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;

  logic [2:0]        cnt_inc;
  logic [1:0]        rd_lane;
  logic [1:0]        wr_lane;
  logic [ADDR_W-1:0] next_a;

  // cnt_q is the index of the current busy cycle; a read captures the byte
  // addressed one cycle earlier, so its lane lags the address by one.
  assign cnt_inc = cnt_q + 3'd1;
  assign rd_lane = 2'(cnt_q - 3'd1);
  assign wr_lane = cnt_inc[1:0];
  assign next_a  = base_q + ADDR_W'(cnt_inc);

  // Next-state, sequencing and result assembly.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    ram_a_d     = ram_a_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_wr_d    = ram_wr_q;
    ram_dout_d  = ram_dout_q;

    unique case (state_q)
      MC_IDLE: begin
        // MEM wins over IF; a port is deaf in the cycle its own done is high.
        if (bus.mem_req && !mem_done_q) begin
          owner_d = OWN_MEM;
          base_d  = bus.mem_addr;
          ram_a_d = bus.mem_addr;
          cnt_d   = 3'd0;
          num_d   = len_bytes(bus.mem_len);
          rbuf_d  = '0;
          if (bus.mem_we) begin
            state_d    = MC_WR;
            wdata_d    = bus.mem_wdata;
            ram_dout_d = bus.mem_wdata[7:0];
            ram_wr_d   = 1'b1;
          end else begin
            state_d = MC_RD;
          end
        end else if (bus.if_req && !if_done_q && !bus.if_flush) begin
          state_d = MC_RD;
          owner_d = OWN_IF;
          base_d  = bus.if_addr;
          ram_a_d = bus.if_addr;
          cnt_d   = 3'd0;
          num_d   = 3'd4;
          rbuf_d  = '0;
        end
      end

      MC_RD: begin
        if (owner_q == OWN_IF && bus.if_flush) begin
          state_d = MC_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q != 3'd0) begin
            rbuf_d[{rd_lane, 3'b000} +: 8] = ram_din;
          end
          if (cnt_inc < num_q) begin
            ram_a_d = next_a;
          end
          if (cnt_q == num_q) begin
            state_d = MC_IDLE;
            if (owner_q == OWN_IF) begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rbuf_d;
            end
          end
        end
      end

      MC_WR: begin
        if (cnt_inc == num_q) begin
          state_d    = MC_IDLE;
          ram_wr_d   = 1'b0;
          ram_dout_d = 8'h00;
          mem_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_inc;
          ram_a_d    = next_a;
          ram_dout_d = wdata_q[{wr_lane, 3'b000} +: 8];
        end
      end

      default: state_d = MC_IDLE;
    endcase
  end

  // State register; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MC_IDLE;
      owner_q     <= OWN_IF;
      base_q      <= '0;
      ram_a_q     <= '0;
      cnt_q       <= 3'd0;
      num_q       <= 3'd0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
    end else if (rdy) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      ram_a_q     <= ram_a_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  // Outputs; the write strobe is also cut by reset so an abort is immediate.
  always_comb begin
    ram_a         = ram_a_q;
    ram_dout      = ram_dout_q;
    ram_wr        = ram_wr_q & rdy & ~rst;
    bus.if_data   = if_data_q;
    bus.if_done   = if_done_q;
    bus.mem_rdata = mem_rdata_q;
    bus.mem_done  = mem_done_q;
    bus.if_stall  = bus.if_req & ~if_done_q;
    bus.mem_stall = bus.mem_req & ~mem_done_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed timing scenarios plus random
// traffic, with a byte-array reference model and per-port expectation queues.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [7:0]    ram_din = 8'h00;
  logic [7:0]    ram_dout;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic          rand_rdy = 1'b0;

  mem_ctrl_if #(.ADDR_W(AW)) bus ();

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .bus      (bus),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int if_cnt = 0;
  int mem_cnt = 0;
  int wr_cnt = 0;
  int exp_wr_cnt = 0;

  typedef struct {
    logic        st;
    logic [31:0] data;
  } exp_t;
  exp_t if_q[$];
  exp_t mem_q[$];

  logic [7:0] ram   [logic [31:0]];
  logic [7:0] model [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return init_byte(a);
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    if (len == 2'b00) return 1;
    if (len == 2'b01) return 2;
    return 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]   = b;
    model[a] = b;
  endtask

  task automatic push_load(input bit is_if, input logic [31:0] a, input int n);
    exp_t e;
    e.st   = 1'b0;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[8*i +: 8] = model_rd(a + 32'(i));
    if (is_if) if_q.push_back(e);
    else mem_q.push_back(e);
  endtask

  task automatic push_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    exp_t e;
    for (int i = 0; i < n; i++) model[a + 32'(i)] = wd[8*i +: 8];
    exp_wr_cnt += n;
    e.st   = 1'b1;
    e.data = '0;
    mem_q.push_back(e);
  endtask

  // RAM model: registered read of the previous cycle's address, held while rdy is low.
  initial forever begin
    @(posedge clk);
    if (ram_wr) begin
      ram[ram_a] = ram_dout;
      wr_cnt++;
    end
    if (rdy) ram_din <= ram_rd(ram_a);
  end

  // Random global enable during the random phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) rdy = ($urandom_range(0, 4) != 0);
  end

  // Monitor: each rising done pops the port's queue and compares the result.
  initial begin
    logic prev_if, prev_mem;
    exp_t e;
    prev_if  = 1'b0;
    prev_mem = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.if_done && !prev_if) begin
        if_cnt++;
        if (if_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL if unexpected done: got if_data %h expected no done", bus.if_data);
        end else begin
          e = if_q.pop_front();
          check("if_data", bus.if_data, e.data);
        end
      end
      if (bus.mem_done && !prev_mem) begin
        mem_cnt++;
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem unexpected done: got mem_rdata %h expected no done",
                   bus.mem_rdata);
        end else begin
          e = mem_q.pop_front();
          if (!e.st) check("mem_rdata", bus.mem_rdata, e.data);
        end
      end
      prev_if  = bus.if_done;
      prev_mem = bus.mem_done;
    end
  end

  // Issue one fetch and/or one data access and wait, bounded, for completion.
  task automatic run_txn(input bit do_if, input bit do_mem, input logic [31:0] ia,
                         input logic we, input logic [1:0] len, input logic [31:0] ma,
                         input logic [31:0] wd);
    int ti, tm, k;
    ti = if_cnt + 1;
    tm = mem_cnt + 1;
    k  = 0;
    if (do_mem) begin
      if (we) push_store(ma, nbytes(len), wd);
      else push_load(1'b0, ma, nbytes(len));
    end
    if (do_if) push_load(1'b1, ia, 4);
    bus.if_addr   = ia;
    bus.mem_we    = we;
    bus.mem_len   = len;
    bus.mem_addr  = ma;
    bus.mem_wdata = wd;
    bus.if_req    = do_if;
    bus.mem_req   = do_mem;
    while ((bus.if_req || bus.mem_req) && k < 400) begin
      step();
      k++;
      if (bus.if_req && if_cnt >= ti) bus.if_req = 1'b0;
      if (bus.mem_req && mem_cnt >= tm) bus.mem_req = 1'b0;
    end
    if (bus.if_req || bus.mem_req) begin
      checks++;
      errors++;
      $display("FAIL txn timeout: got no done after %0d cycles expected done", k);
      bus.if_req  = 1'b0;
      bus.mem_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_wr;
    logic [31:0] ia, ma, wd;
    logic [1:0]  len;
    int          kind;

    rst = 1'b1;
    rdy = 1'b1;
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'b00;
    bus.mem_addr = '0;  bus.mem_wdata = '0;
    repeat (3) step();
    check("reset ram_a", ram_a, 32'h0);
    check("reset ram_wr", ram_wr, 1'b0);
    check("reset ram_dout", ram_dout, 8'h00);
    check("reset if_done", bus.if_done, 1'b0);
    check("reset mem_done", bus.mem_done, 1'b0);
    check("reset if_data", bus.if_data, 32'h0);
    check("reset mem_rdata", bus.mem_rdata, 32'h0);
    rst = 1'b0;
    step();

    // Word fetch at 0x100.
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    push_load(1'b1, 32'h100, 4);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    #1 check("fetch stall c-1", bus.if_stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("fetch ram_a", ram_a, 32'h100 + 32'(i));
      check("fetch stall", bus.if_stall, 1'b1);
    end
    step();
    check("fetch done c4", bus.if_done, 1'b0);
    check("fetch stall c4", bus.if_stall, 1'b1);
    step();
    check("fetch done c5", bus.if_done, 1'b1);
    check("fetch word", bus.if_data, 32'h00100513);
    check("fetch stall c5", bus.if_stall, 1'b0);
    step();
    bus.if_req = 1'b0;

    // Half store at 0x2001.
    push_store(32'h2001, 2, 32'hDEADBEEF);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b01;
    bus.mem_addr = 32'h2001; bus.mem_wdata = 32'hDEADBEEF;
    step();
    check("sth c0 wr", ram_wr, 1'b1);
    check("sth c0 a", ram_a, 32'h2001);
    check("sth c0 dout", ram_dout, 8'hEF);
    step();
    check("sth c1 wr", ram_wr, 1'b1);
    check("sth c1 a", ram_a, 32'h2002);
    check("sth c1 dout", ram_dout, 8'hBE);
    step();
    check("sth c2 done", bus.mem_done, 1'b1);
    check("sth c2 wr", ram_wr, 1'b0);
    check("sth c2 dout", ram_dout, 8'h00);
    step();
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;

    // Contention: byte load at 0x30 against fetch at 0x100.
    preload(32'h30, 8'h80);
    push_load(1'b0, 32'h30, 1);
    push_load(1'b1, 32'h100, 4);
    bus.mem_req = 1'b1; bus.mem_len = 2'b00; bus.mem_addr = 32'h30;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step();
    check("cont c0 a", ram_a, 32'h30);
    step();
    step();
    check("cont mem_done", bus.mem_done, 1'b1);
    check("cont mem_rdata", bus.mem_rdata, 32'h00000080);
    check("cont if_stall", bus.if_stall, 1'b1);
    step();
    bus.mem_req = 1'b0;
    check("cont if accepted", ram_a, 32'h100);
    repeat (4) step();
    check("cont if_done early", bus.if_done, 1'b0);
    step();
    check("cont if_done", bus.if_done, 1'b1);
    step();
    bus.if_req = 1'b0;

    // Flush in cycle 2 of a fetch, then a fresh fetch at 0x200.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step(); step(); step();
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    step();
    bus.if_flush = 1'b0;
    check("flush no done", bus.if_done, 1'b0);
    push_load(1'b1, 32'h200, 4);
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    step();
    check("flush restart a", ram_a, 32'h200);
    repeat (4) step();
    check("flush refetch early", bus.if_done, 1'b0);
    step();
    check("flush refetch done", bus.if_done, 1'b1);
    step();
    bus.if_req = 1'b0;

    // rdy low for three cycles in the middle of a word store.
    base_wr = wr_cnt;
    push_store(32'h40, 4, 32'h11223344);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b11;
    bus.mem_addr = 32'h40; bus.mem_wdata = 32'h11223344;
    step();
    check("rdy c0 dout", ram_dout, 8'h44);
    step();
    check("rdy c1 a", ram_a, 32'h41);
    for (int i = 0; i < 3; i++) begin
      step();
      rdy = 1'b0;
      #1 check("rdy low wr", ram_wr, 1'b0);
    end
    check("rdy low done", bus.mem_done, 1'b0);
    step();
    rdy = 1'b1;
    #1 check("rdy c5 wr", ram_wr, 1'b1);
    check("rdy c5 a", ram_a, 32'h42);
    check("rdy c5 dout", ram_dout, 8'h22);
    step();
    check("rdy c6 a", ram_a, 32'h43);
    check("rdy c6 dout", ram_dout, 8'h11);
    check("rdy c6 done", bus.mem_done, 1'b0);
    step();
    check("rdy c7 done", bus.mem_done, 1'b1);
    step();
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    check("rdy write count", 32'(wr_cnt - base_wr), 32'd4);
    check("rdy stored word", {ram_rd(32'h43), ram_rd(32'h42), ram_rd(32'h41), ram_rd(32'h40)},
          32'h11223344);

    // Reset in cycle 2 of a word load.
    bus.mem_req = 1'b1; bus.mem_len = 2'b11; bus.mem_addr = 32'h50;
    step(); step(); step();
    rst = 1'b1; bus.mem_req = 1'b0;
    step();
    rst = 1'b0;
    check("rst ram_a", ram_a, 32'h0);
    check("rst ram_wr", ram_wr, 1'b0);
    check("rst ram_dout", ram_dout, 8'h00);
    check("rst mem_done", bus.mem_done, 1'b0);
    check("rst mem_rdata", bus.mem_rdata, 32'h0);
    check("rst if_data", bus.if_data, 32'h0);
    repeat (6) step();
    check("rst no late done", bus.mem_done, 1'b0);

    // Random traffic with random rdy.
    rand_rdy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      ia   = 32'h1000 + $urandom_range(0, 63);
      ma   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                         : 32'h3000 + $urandom_range(0, 31);
      len  = 2'($urandom_range(0, 3));
      wd   = $urandom;
      run_txn(kind != 1, kind != 0, ia, 1'($urandom_range(0, 1)), len, ma, wd);
      step();
    end
    rand_rdy = 1'b0;
    rdy = 1'b1;
    repeat (4) step();

    check("if queue drained", 32'(if_q.size()), 32'd0);
    check("mem queue drained", 32'(mem_q.size()), 32'd0);
    check("total ram writes", 32'(wr_cnt), 32'(exp_wr_cnt));
    foreach (model[a]) check("ram contents", {a[23:0], ram_rd(a)}, {a[23:0], model[a]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
